oserdes_gen: RTL and testbench

- Generic multi-lane output serializer; the parametrised successor to the single-bit output DDR register.
- Accepts a parallel word of RATIO bits per lane over a valid/ready handshake and emits it as RATIO/2 bit-pairs per lane.
- Each beat drives one rising-edge bit (q_rise) and one falling-edge bit (q_fall), which feed the per-lane output DDR primitive at the pad.
- Adds buffering, continuous streaming, idle insertion and underrun detection.

---
 rtl/oserdes_gen_pkg.sv | 18 +
 rtl/oserdes_lane.sv | 56 +++++
 rtl/oserdes_gen.sv | 123 ++++++++++++
 tb/tb_oserdes_gen.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/oserdes_gen_pkg.sv
// Shared types and sizing helpers for the oserdes_gen multi-lane output serializer.
package oserdes_gen_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    function automatic int beats(input int ratio);
        return ratio / 2;
    endfunction

    // A single-beat word still needs a 1-bit counter so the compare logic stays uniform.
    function automatic int cnt_width(input int ratio);
        return (beats(ratio) > 1) ? $clog2(beats(ratio)) : 1;
    endfunction

endpackage

// File: rtl/oserdes_lane.sv
// One serial lane: RATIO-bit shifter emitting one registered (rise, fall) bit-pair per beat.
module oserdes_lane #(
    parameter int   RATIO     = 8,
    parameter bit   MSB_FIRST = 1'b1,
    parameter logic IDLE_VAL  = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             active,
    input  logic [RATIO-1:0] load_data,
    output logic             q_rise,
    output logic             q_fall
);

    logic [RATIO-1:0] shift_q, shift_d;
    logic             q_rise_q, q_rise_d;
    logic             q_fall_q, q_fall_d;

    // The pair leaving the shifter this cycle becomes next cycle's pad bits; a load may overwrite it in the same cycle.
    always_comb begin
        shift_d  = shift_q;
        q_rise_d = IDLE_VAL;
        q_fall_d = IDLE_VAL;
        if (active) begin
            if (MSB_FIRST) begin
                q_rise_d = shift_q[RATIO-1];
                q_fall_d = shift_q[RATIO-2];
                shift_d  = shift_q << 2;
            end else begin
                q_rise_d = shift_q[0];
                q_fall_d = shift_q[1];
                shift_d  = shift_q >> 2;
            end
        end
        if (load) begin
            shift_d = load_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q  <= '0;
            q_rise_q <= IDLE_VAL;
            q_fall_q <= IDLE_VAL;
        end else begin
            shift_q  <= shift_d;
            q_rise_q <= q_rise_d;
            q_fall_q <= q_fall_d;
        end
    end

    assign q_rise = q_rise_q;
    assign q_fall = q_fall_q;

endmodule

// File: rtl/oserdes_gen.sv
// Multi-lane output serializer: one-word hold buffer, IDLE/RUN FSM, beat counter and per-lane shifters.
// Define OSERDES_GEN_TRAIN_EN to add the train input and TRAIN_PATTERN parameter.
module oserdes_gen
    import oserdes_gen_pkg::*;
#(
    parameter int   LANES     = 4,
    parameter int   RATIO     = 8,
    parameter bit   MSB_FIRST = 1'b1,
    parameter logic IDLE_VAL  = 1'b0
`ifdef OSERDES_GEN_TRAIN_EN
    ,
    parameter logic [RATIO-1:0] TRAIN_PATTERN = {(RATIO/2){2'b10}}
`endif
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [LANES*RATIO-1:0] s_data,
    input  logic                   s_valid,
    output logic                   s_ready,
`ifdef OSERDES_GEN_TRAIN_EN
    input  logic                   train,
`endif
    output logic [LANES-1:0]       q_rise,
    output logic [LANES-1:0]       q_fall,
    output logic                   busy,
    output logic                   underrun
);

    localparam int             BEATS     = beats(RATIO);
    localparam int             CW        = cnt_width(RATIO);
    localparam logic [CW-1:0]  LAST_BEAT = CW'(BEATS - 1);

    state_t                   state_q, state_d;
    logic [CW-1:0]            beat_cnt_q, beat_cnt_d;
    logic                     hold_full_q, hold_full_d;
    logic [LANES*RATIO-1:0]   hold_data_q, hold_data_d;
    logic                     busy_q, busy_d;
    logic                     underrun_q, underrun_d;

    logic                     train_now;
    logic [RATIO-1:0]         train_word;
    logic                     load_opp;
    logic                     load;
    logic                     train_load;
    logic                     accept;
    logic [LANES*RATIO-1:0]   lane_data;

`ifdef OSERDES_GEN_TRAIN_EN
    assign train_now  = train;
    assign train_word = TRAIN_PATTERN;
`else
    assign train_now  = 1'b0;
    assign train_word = '0;
`endif

    // busy and underrun are registered so they line up with the registered pad bits.
    always_comb begin
        load_opp    = (state_q == IDLE) || (beat_cnt_q == LAST_BEAT);
        train_load  = train_now && load_opp;
        load        = hold_full_q && load_opp && !train_now;
        s_ready     = !hold_full_q || load;
        accept      = s_valid && s_ready;
        lane_data   = train_load ? {LANES{train_word}} : hold_data_q;

        hold_full_d = accept || (hold_full_q && !load);
        hold_data_d = accept ? s_data : hold_data_q;

        state_d     = state_q;
        beat_cnt_d  = beat_cnt_q;
        if (load || train_load) begin
            state_d    = RUN;
            beat_cnt_d = '0;
        end else if (state_q == RUN) begin
            if (beat_cnt_q == LAST_BEAT) begin
                state_d    = IDLE;
                beat_cnt_d = '0;
            end else begin
                beat_cnt_d = beat_cnt_q + 1'b1;
            end
        end

        busy_d      = (state_q == RUN);
        underrun_d  = busy_q && (state_q == IDLE) && !train_now;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            beat_cnt_q  <= '0;
            hold_full_q <= 1'b0;
            hold_data_q <= '0;
            busy_q      <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_cnt_q  <= beat_cnt_d;
            hold_full_q <= hold_full_d;
            hold_data_q <= hold_data_d;
            busy_q      <= busy_d;
            underrun_q  <= underrun_d;
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        oserdes_lane #(
            .RATIO     (RATIO),
            .MSB_FIRST (MSB_FIRST),
            .IDLE_VAL  (IDLE_VAL)
        ) u_lane (
            .clk       (clk),
            .rst_n     (rst_n),
            .load      (load || train_load),
            .active    (state_q == RUN),
            .load_data (lane_data[l*RATIO +: RATIO]),
            .q_rise    (q_rise[l]),
            .q_fall    (q_fall[l])
        );
    end

    assign busy     = busy_q;
    assign underrun = underrun_q;

endmodule

// File: tb/tb_oserdes_gen.sv
// Directed self-checking bench for oserdes_gen (4x8 MSB-first instance plus a 2x2 LSB-first instance).
module tb_oserdes_gen;

    typedef struct packed {
        logic        valid;
        logic [31:0] data;
        logic [10:0] exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic [3:0]  q_rise;
    logic [3:0]  q_fall;
    logic        busy;
    logic        underrun;
    logic        train;

    logic [3:0]  s_data2;
    logic        s_valid2;
    logic        s_ready2;
    logic [1:0]  q_rise2;
    logic [1:0]  q_fall2;
    logic        busy2;
    logic        underrun2;
    logic        train2;

    int tests  = 0;
    int failed = 0;

    vec_t single_vec [9];

    always #5 clk = ~clk;

    oserdes_gen #(
        .LANES(4), .RATIO(8), .MSB_FIRST(1'b1), .IDLE_VAL(1'b0)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .s_data   (s_data),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
`ifdef OSERDES_GEN_TRAIN_EN
        .train    (train),
`endif
        .q_rise   (q_rise),
        .q_fall   (q_fall),
        .busy     (busy),
        .underrun (underrun)
    );

    oserdes_gen #(
        .LANES(2), .RATIO(2), .MSB_FIRST(1'b0), .IDLE_VAL(1'b0)
    ) dut2 (
        .clk      (clk),
        .rst_n    (rst_n),
        .s_data   (s_data2),
        .s_valid  (s_valid2),
        .s_ready  (s_ready2),
`ifdef OSERDES_GEN_TRAIN_EN
        .train    (train2),
`endif
        .q_rise   (q_rise2),
        .q_fall   (q_fall2),
        .busy     (busy2),
        .underrun (underrun2)
    );

    function automatic logic [10:0] mkExp(input logic rdy, input logic bsy, input logic und,
                                          input logic [3:0] r, input logic [3:0] f);
        return {rdy, bsy, und, r, f};
    endfunction

    function automatic logic [10:0] obs();
        return {s_ready, busy, underrun, q_rise, q_fall};
    endfunction

    function automatic logic [6:0] obs2();
        return {s_ready2, busy2, underrun2, q_rise2, q_fall2};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [31:0] d);
        s_valid = v;
        s_data  = d;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int sent, b, und, rises, hits, bad, last;
        logic acc, prev_busy;
        logic [7:0] w;
        logic er, ef;
        logic [10:0] e;

        rst_n    = 1'b0;
        s_valid  = 1'b0;
        s_data   = '0;
        s_valid2 = 1'b0;
        s_data2  = '0;
        train    = 1'b0;
        train2   = 1'b0;

        // Single word: lane0 = A5, other lanes zero; columns are {ready,busy,underrun,rise,fall}.
        single_vec[0] = '{1'b1, 32'h0000_00A5, mkExp(1, 0, 0, 4'h0, 4'h0)};
        single_vec[1] = '{1'b0, 32'h0,         mkExp(1, 0, 0, 4'h0, 4'h0)};
        single_vec[2] = '{1'b0, 32'h0,         mkExp(1, 0, 0, 4'h0, 4'h0)};
        single_vec[3] = '{1'b0, 32'h0,         mkExp(1, 1, 0, 4'h1, 4'h0)};
        single_vec[4] = '{1'b0, 32'h0,         mkExp(1, 1, 0, 4'h1, 4'h0)};
        single_vec[5] = '{1'b0, 32'h0,         mkExp(1, 1, 0, 4'h0, 4'h1)};
        single_vec[6] = '{1'b0, 32'h0,         mkExp(1, 1, 0, 4'h0, 4'h1)};
        single_vec[7] = '{1'b0, 32'h0,         mkExp(1, 0, 1, 4'h0, 4'h0)};
        single_vec[8] = '{1'b0, 32'h0,         mkExp(1, 0, 0, 4'h0, 4'h0)};

        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            tick();
            checkOutput($sformatf("idle_%0d", i), 32'(obs()), 32'(mkExp(1, 0, 0, 4'h0, 4'h0)));
        end

        for (int i = 0; i < 9; i++) begin
            tick();
            checkOutput($sformatf("single_row%0d", i), 32'(obs()), 32'(single_vec[i].exp));
            applyStimulus(single_vec[i].valid, single_vec[i].data);
        end

        // Streaming: words 0..15 on every lane with valid held whenever a word remains.
        applyStimulus(1'b1, 32'h0);
        acc = s_valid && s_ready;
        sent = 0; b = 0; und = 0; rises = 0; hits = 0; bad = 0; last = -1;
        prev_busy = 1'b0;
        for (int c = 0; c < 80; c++) begin
            tick();
            if (acc) sent++;
            if (sent < 16) applyStimulus(1'b1, {4{8'(sent)}});
            else           applyStimulus(1'b0, 32'h0);
            if (busy && !prev_busy) rises++;
            if (busy) begin
                if (b < 64) begin
                    w  = 8'(b / 4);
                    er = w[7 - 2*(b % 4)];
                    ef = w[6 - 2*(b % 4)];
                    checkOutput($sformatf("stream_beat%0d", b), {24'h0, q_rise, q_fall}, {24'h0, {4{er}}, {4{ef}}});
                end
                b++;
                if (sent < 16 && s_ready) begin
                    if (last >= 0 && (c - last) != 4) bad++;
                    last = c;
                    hits++;
                end
            end
            if (underrun) begin
                und++;
                checkOutput("stream_underrun_idle", {23'h0, busy, q_rise, q_fall}, 32'h0);
            end
            prev_busy = busy;
            acc = s_valid && s_ready;
        end
        checkOutput("stream_beats", 32'(b), 32'd64);
        checkOutput("stream_bursts", 32'(rises), 32'd1);
        checkOutput("stream_underruns", 32'(und), 32'd1);
        checkOutput("stream_ready_hits", 32'(hits), 32'd14);
        checkOutput("stream_ready_period", 32'(bad), 32'd0);

        // Reset during beat 2 of a word with a second word waiting in hold.
        applyStimulus(1'b1, 32'hFFFF_FFFF);
        tick();
        tick();
        applyStimulus(1'b0, 32'h0);
        tick();
        tick();
        tick();
        checkOutput("rst_pre_beat2", {24'h0, q_rise, q_fall}, 32'h0000_00FF);
        #2 rst_n = 1'b0;
        #1 checkOutput("rst_async", 32'(obs()), 32'(mkExp(1, 0, 0, 4'h0, 4'h0)));
        #2 rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            checkOutput($sformatf("rst_after_%0d", i), 32'(obs()), 32'(mkExp(1, 0, 0, 4'h0, 4'h0)));
        end

        // RATIO=2, LSB first: lane0 = 01, lane1 = 10 every cycle.
        s_valid2 = 1'b1;
        s_data2  = 4'b1001;
        for (int i = 1; i <= 12; i++) begin
            tick();
            checkOutput($sformatf("r2_cycle%0d", i), 32'(obs2()),
                        (i < 3) ? 32'b100_00_00 : 32'b110_01_10);
            if (i == 12) begin
                s_valid2 = 1'b0;
                s_data2  = 4'b0000;
            end
        end
        und = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (underrun2) und++;
        end
        checkOutput("r2_underruns", 32'(und), 32'd1);

`ifdef OSERDES_GEN_TRAIN_EN
        // Training holds the pending FF word until train drops at a word boundary.
        train = 1'b1;
        applyStimulus(1'b1, 32'hFFFF_FFFF);
        for (int m = 0; m <= 18; m++) begin
            tick();
            if (m == 0) applyStimulus(1'b0, 32'h0);
            if (m == 0)       e = mkExp(0, 0, 0, 4'h0, 4'h0);
            else if (m <= 10) e = mkExp(0, 1, 0, 4'hF, 4'h0);
            else if (m <= 12) e = mkExp(1, 1, 0, 4'hF, 4'h0);
            else if (m <= 16) e = mkExp(1, 1, 0, 4'hF, 4'hF);
            else if (m == 17) e = mkExp(1, 0, 1, 4'h0, 4'h0);
            else              e = mkExp(1, 0, 0, 4'h0, 4'h0);
            checkOutput($sformatf("train_m%0d", m), 32'(obs()), 32'(e));
            if (m == 8) train = 1'b0;
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
